// File: rtl/mac16_seq_ctrl.sv
// Operand sequencer for the mac_16 array: preloads tile 0 A rows, then streams B
// beats per tile while prefetching the next tile's A rows into a shadow register.
module mac16_seq_ctrl #(
    parameter int VEC_W     = 264,
    parameter int ROWS      = 16,
    parameter int MAX_TILES = 128,
    parameter int ADDR_W    = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode_sel,
    input  logic                  vsq_en,
    input  logic [7:0]            num_tiles,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic                  a_sram_ren,
    output logic [ADDR_W-1:0]     a_sram_addr,
    input  logic [VEC_W-1:0]      a_sram_rdata,
    output logic                  b_sram_ren,
    output logic [ADDR_W-1:0]     b_sram_addr,
    input  logic [VEC_W-1:0]      b_sram_rdata,
    output logic [ROWS*VEC_W-1:0] a_vec,
    output logic [VEC_W-1:0]      b_vec,
    output logic                  mac_valid,
    output logic                  mac_clear,
    output logic                  is_int8_mode,
    output logic                  is_int4_mode,
    output logic                  is_vsq
);

    localparam int ROW_W = $clog2(ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] DRAIN_END = ROW_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_PRELOAD, S_RUN, S_DRAIN} state_t;

    state_t                 state_q;
    logic [ROW_W-1:0]       row_q;
    logic [7:0]             tile_q, ntiles_q;
    logic                   busy_q, done_q, cfg_err_q;
    logic                   a_ren_q, b_ren_q;
    logic [ADDR_W-1:0]      a_addr_q, b_addr_q;
    logic                   int8_q, int4_q, vsq_q;

    logic                   a_cap_q, b_cap_q, b_cap_first_q, b_cap_clear_q;
    logic [ROW_W-1:0]       a_cap_row_q;
    logic [ROWS*VEC_W-1:0]  shadow_q, a_vec_q;
    logic [VEC_W-1:0]       b_vec_q;
    logic                   mac_valid_q, mac_clear_q;

    logic cfg_ok;
    logic kill;

    assign cfg_ok = ((mode_sel == 2'b01) || (mode_sel == 2'b10)) &&
                    (num_tiles != 8'd0) && (num_tiles <= 8'(MAX_TILES));
    assign kill   = abort && (state_q != S_IDLE);

    // Control FSM; every output it drives is registered and describes the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            tile_q    <= '0;
            ntiles_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            a_ren_q   <= 1'b0;
            a_addr_q  <= '0;
            b_ren_q   <= 1'b0;
            b_addr_q  <= '0;
            int8_q    <= 1'b0;
            int4_q    <= 1'b0;
            vsq_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            if (kill) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                a_ren_q <= 1'b0;
                b_ren_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            if (cfg_ok) begin
                                state_q  <= S_PRELOAD;
                                busy_q   <= 1'b1;
                                row_q    <= '0;
                                tile_q   <= '0;
                                ntiles_q <= num_tiles;
                                int8_q   <= (mode_sel == 2'b01);
                                int4_q   <= (mode_sel == 2'b10);
                                vsq_q    <= vsq_en;
                                a_ren_q  <= 1'b1;
                                a_addr_q <= '0;
                            end else begin
                                cfg_err_q <= 1'b1;
                            end
                        end
                    end
                    S_PRELOAD: begin
                        row_q <= row_q + 1'b1;
                        if (row_q == LAST_ROW) begin
                            state_q  <= S_RUN;
                            tile_q   <= '0;
                            b_ren_q  <= 1'b1;
                            b_addr_q <= '0;
                            a_ren_q  <= (ntiles_q > 8'd1);
                            if (ntiles_q > 8'd1) a_addr_q <= a_addr_q + 1'b1;
                        end else begin
                            a_addr_q <= a_addr_q + 1'b1;
                        end
                    end
                    S_RUN: begin
                        row_q <= row_q + 1'b1;
                        if (row_q == LAST_ROW) begin
                            if (tile_q + 8'd1 == ntiles_q) begin
                                state_q <= S_DRAIN;
                                row_q   <= '0;
                                a_ren_q <= 1'b0;
                                b_ren_q <= 1'b0;
                            end else begin
                                tile_q   <= tile_q + 8'd1;
                                b_addr_q <= b_addr_q + 1'b1;
                                // No prefetch while streaming the final tile.
                                a_ren_q  <= (tile_q + 8'd2 < ntiles_q);
                                if (tile_q + 8'd2 < ntiles_q) a_addr_q <= a_addr_q + 1'b1;
                            end
                        end else begin
                            b_addr_q <= b_addr_q + 1'b1;
                            if (a_ren_q) a_addr_q <= a_addr_q + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        row_q <= row_q + 1'b1;
                        if (row_q == DRAIN_END) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Read-data capture and operand output stage; a_vec commits the pre-edge shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cap_q       <= 1'b0;
            a_cap_row_q   <= '0;
            b_cap_q       <= 1'b0;
            b_cap_first_q <= 1'b0;
            b_cap_clear_q <= 1'b0;
            shadow_q      <= '0;
            a_vec_q       <= '0;
            b_vec_q       <= '0;
            mac_valid_q   <= 1'b0;
            mac_clear_q   <= 1'b0;
        end else begin
            a_cap_q       <= a_ren_q && !kill;
            a_cap_row_q   <= a_addr_q[ROW_W-1:0];
            b_cap_q       <= b_ren_q && !kill;
            b_cap_first_q <= (b_addr_q[ROW_W-1:0] == '0);
            b_cap_clear_q <= (b_addr_q == '0);
            if (a_cap_q && !kill) begin
                shadow_q[int'(a_cap_row_q)*VEC_W +: VEC_W] <= a_sram_rdata;
            end
            mac_valid_q <= b_cap_q && !kill;
            mac_clear_q <= b_cap_q && !kill && b_cap_clear_q;
            if (b_cap_q && !kill) begin
                b_vec_q <= b_sram_rdata;
                if (b_cap_first_q) a_vec_q <= shadow_q;
            end
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;
    assign a_sram_ren   = a_ren_q;
    assign a_sram_addr  = a_addr_q;
    assign b_sram_ren   = b_ren_q;
    assign b_sram_addr  = b_addr_q;
    assign a_vec        = a_vec_q;
    assign b_vec        = b_vec_q;
    assign mac_valid    = mac_valid_q;
    assign mac_clear    = mac_clear_q;
    assign is_int8_mode = int8_q;
    assign is_int4_mode = int4_q;
    assign is_vsq       = vsq_q;

endmodule

// File: tb/tb_mac16_seq_ctrl.sv
// Bench for mac16_seq_ctrl: SRAM models, a cycle-indexed job reference model,
// a configuration vector table and hand-written abort/reset/long-job sequences.
module tb_mac16_seq_ctrl;

    localparam int VEC_W     = 264;
    localparam int ROWS      = 16;
    localparam int MAX_TILES = 128;
    localparam int ADDR_W    = 11;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start, abort, vsq_en;
    logic [1:0]            mode_sel;
    logic [7:0]            num_tiles;
    logic                  busy, done, cfg_err;
    logic                  a_sram_ren, b_sram_ren;
    logic [ADDR_W-1:0]     a_sram_addr, b_sram_addr;
    logic [VEC_W-1:0]      a_sram_rdata, b_sram_rdata, b_vec;
    logic [ROWS*VEC_W-1:0] a_vec;
    logic                  mac_valid, mac_clear, is_int8_mode, is_int4_mode, is_vsq;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] salt;
    logic        exp_int8, exp_int4, exp_vsq;

    typedef struct {
        logic [1:0] mode;
        logic       vsq;
        logic [7:0] ntiles;
        logic       exp_err;
        logic       exp_i8;
        logic       exp_i4;
        logic       exp_vs;
    } cfg_vec_t;

    cfg_vec_t tbl[9];

    always #5 clk = ~clk;

    mac16_seq_ctrl #(.VEC_W(VEC_W), .ROWS(ROWS), .MAX_TILES(MAX_TILES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode_sel(mode_sel),
        .vsq_en(vsq_en), .num_tiles(num_tiles), .busy(busy), .done(done), .cfg_err(cfg_err),
        .a_sram_ren(a_sram_ren), .a_sram_addr(a_sram_addr), .a_sram_rdata(a_sram_rdata),
        .b_sram_ren(b_sram_ren), .b_sram_addr(b_sram_addr), .b_sram_rdata(b_sram_rdata),
        .a_vec(a_vec), .b_vec(b_vec), .mac_valid(mac_valid), .mac_clear(mac_clear),
        .is_int8_mode(is_int8_mode), .is_int4_mode(is_int4_mode), .is_vsq(is_vsq)
    );

    function automatic logic [VEC_W-1:0] a_word(input logic [ADDR_W-1:0] a);
        return {salt, 216'd0, 4'hA, 1'b0, a};
    endfunction

    function automatic logic [VEC_W-1:0] b_word(input logic [ADDR_W-1:0] a);
        return {salt, 216'd0, 4'hB, 1'b0, a};
    endfunction

    // SRAMs: one-cycle read latency, word content derived from the address.
    initial begin
        a_sram_rdata = '0;
        b_sram_rdata = '0;
    end
    always @(posedge clk) begin
        if (a_sram_ren) a_sram_rdata <= a_word(a_sram_addr);
        if (b_sram_ren) b_sram_rdata <= b_word(b_sram_addr);
    end

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b, want %0b", name, act, exp);
        end
    endtask

    task automatic chk_n(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Expected outputs for cycle 'cyc' of an N-tile job started in cycle 0,
    // optionally aborted in cycle kill_cyc.
    task automatic check_cycle(input int cyc, input int n, input int kill_cyc);
        bit live, e_busy, e_done, e_aren, e_bren, e_val;
        int last, t, bad;
        live   = (kill_cyc < 0) || (cyc <= kill_cyc);
        last   = 18 + 16 * n;
        e_busy = live && cyc >= 1 && cyc <= last;
        e_done = live && cyc == last + 1;
        e_aren = live && cyc >= 1 && cyc <= 16 * n;
        e_bren = live && cyc >= 17 && cyc <= 16 + 16 * n;
        e_val  = live && cyc >= 19 && cyc <= last;
        chk_b($sformatf("busy@%0d", cyc), busy, e_busy);
        chk_b($sformatf("done@%0d", cyc), done, e_done);
        chk_b($sformatf("cfg_err@%0d", cyc), cfg_err, 1'b0);
        chk_b($sformatf("a_ren@%0d", cyc), a_sram_ren, e_aren);
        chk_b($sformatf("b_ren@%0d", cyc), b_sram_ren, e_bren);
        chk_b($sformatf("mac_valid@%0d", cyc), mac_valid, e_val);
        chk_b($sformatf("mac_clear@%0d", cyc), mac_clear, live && cyc == 19);
        chk_b($sformatf("int8@%0d", cyc), is_int8_mode, exp_int8);
        chk_b($sformatf("int4@%0d", cyc), is_int4_mode, exp_int4);
        chk_b($sformatf("vsq@%0d", cyc), is_vsq, exp_vsq);
        if (e_aren) chk_n($sformatf("a_addr@%0d", cyc), 64'(a_sram_addr), 64'(cyc - 1));
        if (e_bren) chk_n($sformatf("b_addr@%0d", cyc), 64'(b_sram_addr), 64'(cyc - 17));
        if (e_val) begin
            chk_w($sformatf("b_vec@%0d", cyc), b_vec, b_word(ADDR_W'(cyc - 19)));
            t   = (cyc - 19) / 16;
            bad = -1;
            for (int r = 0; r < ROWS; r++) begin
                if (bad < 0 && a_vec[r*VEC_W +: VEC_W] !== a_word(ADDR_W'(t * 16 + r))) bad = r;
            end
            n_vec++;
            if (bad >= 0) begin
                n_err++;
                $display("FAIL a_vec@%0d row %0d: got %0h, want %0h", cyc, bad,
                         a_vec[bad*VEC_W +: VEC_W], a_word(ADDR_W'(t * 16 + bad)));
            end
        end else if (kill_cyc < 0 && cyc > last) begin
            chk_w($sformatf("b_vec_hold@%0d", cyc), b_vec, b_word(ADDR_W'(16 * n - 1)));
        end
    endtask

    // Starts a job and checks every cycle through the return to idle.
    // xs: cycle of an extra start pulse; kill: abort cycle; rc: reset cycle (-1 = none).
    task automatic run_job(input logic [1:0] m, input logic v, input int n,
                           input int xs, input int kill, input int rc);
        int beats;
        beats = 0;
        salt  = $urandom;
        @(negedge clk);
        mode_sel  = m;
        vsq_en    = v;
        num_tiles = 8'(n);
        start     = 1'b1;
        for (int cyc = 1; cyc <= 20 + 16 * n; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (cyc == rc) begin
                rst = 1'b1;
                #1;
                chk_b("rst_busy", busy, 1'b0);
                chk_b("rst_done", done, 1'b0);
                chk_b("rst_cfg_err", cfg_err, 1'b0);
                chk_b("rst_a_ren", a_sram_ren, 1'b0);
                chk_b("rst_b_ren", b_sram_ren, 1'b0);
                chk_n("rst_a_addr", 64'(a_sram_addr), 64'd0);
                chk_n("rst_b_addr", 64'(b_sram_addr), 64'd0);
                chk_b("rst_a_vec_zero", a_vec == '0, 1'b1);
                chk_w("rst_b_vec", b_vec, '0);
                chk_b("rst_mac_valid", mac_valid, 1'b0);
                chk_b("rst_mac_clear", mac_clear, 1'b0);
                chk_b("rst_strobes", is_int8_mode | is_int4_mode | is_vsq, 1'b0);
                @(negedge clk);
                chk_b("rst_hold_done", done, 1'b0);
                rst = 1'b0;
                exp_int8 = 1'b0;
                exp_int4 = 1'b0;
                exp_vsq  = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk_b("post_rst_done", done, 1'b0);
                    chk_b("post_rst_busy", busy, 1'b0);
                end
                return;
            end
            check_cycle(cyc, n, kill);
            if (mac_valid) beats++;
            if (cyc == xs) begin
                start     = 1'b1;
                mode_sel  = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'b10;
                num_tiles = 8'd3;
            end
            if (cyc == kill) abort = 1'b1;
        end
        chk_n("beat_count", 64'(beats), (kill < 0) ? 64'(16 * n) : 64'(kill - 18));
    endtask

    task automatic try_reject(input logic [1:0] m, input logic v, input logic [7:0] n);
        @(negedge clk);
        mode_sel  = m;
        vsq_en    = v;
        num_tiles = n;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_b("rej_cfg_err", cfg_err, 1'b1);
        chk_b("rej_busy", busy, 1'b0);
        chk_b("rej_a_ren", a_sram_ren, 1'b0);
        chk_b("rej_b_ren", b_sram_ren, 1'b0);
        chk_b("rej_int8_hold", is_int8_mode, exp_int8);
        chk_b("rej_int4_hold", is_int4_mode, exp_int4);
        chk_b("rej_vsq_hold", is_vsq, exp_vsq);
        @(negedge clk);
        chk_b("rej_cfg_err_clear", cfg_err, 1'b0);
        chk_b("rej_busy2", busy, 1'b0);
        chk_b("rej_a_ren2", a_sram_ren, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running, want finished");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] m;
        logic       v;
        int         n;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode_sel = 2'b00; vsq_en = 1'b0;
        num_tiles = 8'd0; salt = '0;
        exp_int8 = 1'b0; exp_int4 = 1'b0; exp_vsq = 1'b0;

        tbl[0] = '{2'b01, 1'b0, 8'd1,   1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{2'b11, 1'b0, 8'd4,   1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{2'b10, 1'b1, 8'd0,   1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{2'b10, 1'b1, 8'd129, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{2'b00, 1'b1, 8'd2,   1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{2'b10, 1'b1, 8'd2,   1'b0, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{2'b01, 1'b0, 8'd255, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{2'b01, 1'b1, 8'd3,   1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{2'b10, 1'b0, 8'd1,   1'b0, 1'b0, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk_b("reset_busy", busy, 1'b0);
        chk_b("reset_done", done, 1'b0);
        chk_b("reset_cfg_err", cfg_err, 1'b0);
        chk_b("reset_a_ren", a_sram_ren, 1'b0);
        chk_b("reset_b_ren", b_sram_ren, 1'b0);
        chk_b("reset_mac_valid", mac_valid, 1'b0);
        chk_b("reset_mac_clear", mac_clear, 1'b0);
        chk_b("reset_a_vec_zero", a_vec == '0, 1'b1);
        chk_w("reset_b_vec", b_vec, '0);
        chk_b("reset_strobes", is_int8_mode | is_int4_mode | is_vsq, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].exp_err) begin
                try_reject(tbl[i].mode, tbl[i].vsq, tbl[i].ntiles);
            end else begin
                exp_int8 = tbl[i].exp_i8;
                exp_int4 = tbl[i].exp_i4;
                exp_vsq  = tbl[i].exp_vs;
                run_job(tbl[i].mode, tbl[i].vsq, int'(tbl[i].ntiles), -1, -1, -1);
            end
        end

        for (int i = 0; i < 6; i++) begin
            m = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            v = 1'(($urandom_range(0, 1)));
            n = $urandom_range(1, 5);
            exp_int8 = (m == 2'b01);
            exp_int4 = (m == 2'b10);
            exp_vsq  = v;
            run_job(m, v, n, $urandom_range(18, 16 + 16 * n), -1, -1);
        end

        // Longest job: top addresses and every tile-boundary commit.
        exp_int8 = 1'b0; exp_int4 = 1'b1; exp_vsq = 1'b1;
        run_job(2'b10, 1'b1, 128, -1, -1, -1);

        // Abort in the cycle after tile 1 row 7 is read.
        exp_int8 = 1'b1; exp_int4 = 1'b0; exp_vsq = 1'b0;
        run_job(2'b01, 1'b0, 4, -1, 41, -1);

        // Abort alone in idle, then abort together with a legal start.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_b("idle_abort_busy", busy, 1'b0);
        mode_sel = 2'b10; num_tiles = 8'd2; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk_b("abort_start_busy", busy, 1'b0);
        chk_b("abort_start_a_ren", a_sram_ren, 1'b0);
        chk_b("abort_start_cfg_err", cfg_err, 1'b0);
        chk_b("abort_start_int8_hold", is_int8_mode, exp_int8);
        @(negedge clk);
        chk_b("abort_start_busy2", busy, 1'b0);

        // Reset mid-run at tile 3, then a clean job.
        exp_int8 = 1'b0; exp_int4 = 1'b1; exp_vsq = 1'b0;
        run_job(2'b10, 1'b0, 5, -1, -1, 17 + 48 + 5);
        exp_int8 = 1'b1; exp_int4 = 1'b0; exp_vsq = 1'b1;
        run_job(2'b01, 1'b1, 2, -1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
